stopwatch_ctrl: RTL

Parametrised stopwatch controller: the next generation of the three-switch `control` FSM. It synchronises and edge-detects three push switches and runs a start/stop/clear state machine. It owns a prescaler and a WIDTH-bit counter, so downstream datapath/display logic receives ready-made `ci`/`ld`/`clr` strobes plus the count itself. It sits between the board switch inputs and the display/datapath registers.

---
 rtl/stopwatch_pkg.sv | 15 +
 rtl/sw_edge.sv | 34 +++
 rtl/stopwatch_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg
// Shared definitions for the stopwatch controller: the FSM state width and
// the state encodings that appear on the `state` output port.
package stopwatch_pkg;

    localparam int ST_W = 2;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_STOP = 2'b10,
        ST_DONE = 2'b11
    } state_e;

endpackage

// File: rtl/sw_edge.sv
// sw_edge
// Brings one asynchronous push-switch level into the clk domain and turns
// each rising edge into a single-cycle event.
//   clk     in   system clock
//   rst     in   asynchronous active-high reset
//   sw_i    in   raw switch level (asynchronous)
//   rise_o  out  one-cycle event, high the cycle after the synchronised level rises
module sw_edge (
    input  logic clk,
    input  logic rst,
    input  logic sw_i,
    output logic rise_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sw_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // prev_q clears on reset, so a switch held through reset still gives one event
    assign rise_o = sync2_q & ~prev_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl
// Start/stop/clear stopwatch controller with its own prescaler and counter.
// Three switches are synchronised and edge-detected; the FSM then produces
// registered strobes for the downstream datapath together with the count.
//   clk     in   system clock
//   rst     in   asynchronous active-high reset
//   sw1     in   start/resume (also lap when STOPWATCH_CTRL_LAP_EN is defined)
//   sw2     in   clear
//   sw3     in   stop
//   ci      out  count-increment strobe
//   ld      out  load strobe on RUN->STOP
//   clr     out  clear strobe
//   ovf     out  wrap strobe (WRAP=1 only)
//   count   out  current count
//   hold    out  count captured at the last stop
//   state   out  FSM state (IDLE=00 RUN=01 STOP=10 DONE=11)
//   lap     out  lap capture      (only with STOPWATCH_CTRL_LAP_EN)
//   lap_ld  out  lap load strobe  (only with STOPWATCH_CTRL_LAP_EN)
// Optional feature macro: STOPWATCH_CTRL_LAP_EN
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DIV   = 4,
    parameter int MAX   = 9,
    parameter int WRAP  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sw1,
    input  logic             sw2,
    input  logic             sw3,
    output logic             ci,
    output logic             ld,
    output logic             clr,
    output logic             ovf,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] hold,
    output logic [ST_W-1:0]  state
`ifdef STOPWATCH_CTRL_LAP_EN
    ,
    output logic [WIDTH-1:0] lap,
    output logic             lap_ld
`endif
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]    PRESC_LAST = PW'(DIV - 1);
    localparam logic [WIDTH-1:0] MAX_V      = WIDTH'(MAX);

    logic ev_start;
    logic ev_clr;
    logic ev_stop;

    sw_edge u_sw1 (.clk(clk), .rst(rst), .sw_i(sw1), .rise_o(ev_start));
    sw_edge u_sw2 (.clk(clk), .rst(rst), .sw_i(sw2), .rise_o(ev_clr));
    sw_edge u_sw3 (.clk(clk), .rst(rst), .sw_i(sw3), .rise_o(ev_stop));

    state_e           state_q;
    logic [PW-1:0]    presc_q;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] hold_q;
    logic             ci_q;
    logic             ld_q;
    logic             clr_q;
    logic             ovf_q;
`ifdef STOPWATCH_CTRL_LAP_EN
    logic [WIDTH-1:0] lap_q;
    logic             lap_ld_q;
`endif

    assign count_d = count_q + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            presc_q  <= '0;
            count_q  <= '0;
            hold_q   <= '0;
            ci_q     <= 1'b0;
            ld_q     <= 1'b0;
            clr_q    <= 1'b0;
            ovf_q    <= 1'b0;
`ifdef STOPWATCH_CTRL_LAP_EN
            lap_q    <= '0;
            lap_ld_q <= 1'b0;
`endif
        end else begin
            ci_q     <= 1'b0;
            ld_q     <= 1'b0;
            clr_q    <= 1'b0;
            ovf_q    <= 1'b0;
`ifdef STOPWATCH_CTRL_LAP_EN
            lap_ld_q <= 1'b0;
`endif
            // clear has top priority and acts identically from every state
            if (ev_clr) begin
                state_q <= ST_IDLE;
                presc_q <= '0;
                count_q <= '0;
                hold_q  <= '0;
                clr_q   <= 1'b1;
`ifdef STOPWATCH_CTRL_LAP_EN
                lap_q   <= '0;
`endif
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (ev_start) begin
                            state_q <= ST_RUN;
                            presc_q <= '0;
                        end
                    end
                    ST_RUN: begin
                        if (ev_stop) begin
                            // stop wins over a coincident tick: prescaler stays put
                            state_q <= ST_STOP;
                            hold_q  <= count_q;
                            ld_q    <= 1'b1;
                        end else begin
`ifdef STOPWATCH_CTRL_LAP_EN
                            if (ev_start) begin
                                lap_q    <= count_q;
                                lap_ld_q <= 1'b1;
                            end
`endif
                            if (presc_q == PRESC_LAST) begin
                                presc_q <= '0;
                                if (count_q == MAX_V) begin
                                    // only reachable with WRAP=0 when MAX=0
                                    if (WRAP != 0) begin
                                        count_q <= '0;
                                        ci_q    <= 1'b1;
                                        ovf_q   <= 1'b1;
                                    end else begin
                                        state_q <= ST_DONE;
                                    end
                                end else begin
                                    count_q <= count_d;
                                    ci_q    <= 1'b1;
                                    if (WRAP == 0 && count_d == MAX_V) begin
                                        state_q <= ST_DONE;
                                    end
                                end
                            end else begin
                                presc_q <= presc_q + 1'b1;
                            end
                        end
                    end
                    ST_STOP: begin
                        if (ev_start) begin
                            state_q <= ST_RUN;
                        end
                    end
                    ST_DONE: begin
                    end
                endcase
            end
        end
    end

    assign ci    = ci_q;
    assign ld    = ld_q;
    assign clr   = clr_q;
    assign ovf   = ovf_q;
    assign count = count_q;
    assign hold  = hold_q;
    assign state = state_q;
`ifdef STOPWATCH_CTRL_LAP_EN
    assign lap    = lap_q;
    assign lap_ld = lap_ld_q;
`endif

endmodule
